// File: rtl/discrete_audio_mixer.sv
// Serial audio mixer: per-tick channel snapshot, shared-multiplier gain/mute accumulation,
// unsigned saturation, leaky-integrator DC removal and a registered signed 16-bit sample.
module discrete_audio_mixer #(
  parameter int NUM_CH   = 4,
  parameter int GAIN_W   = 8,
  parameter int DC_SHIFT = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clk_48KHz_en,
  input  logic [NUM_CH*16-1:0]     ch_in,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  input  logic [NUM_CH-1:0]        ch_mute,
  output logic [15:0]              audio_out,
  output logic                     audio_valid,
  output logic                     overrun
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = 16 + GAIN_W;
  localparam int ACC_W  = 16 + GAIN_W + $clog2(NUM_CH);
  localparam int SHR_W  = ACC_W - 7;
  localparam int DCA_W  = 16 + DC_SHIFT;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_SAT, S_DCBLK, S_OUT} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [15:0]       r_in   [NUM_CH];
  logic [GAIN_W-1:0] r_gain [NUM_CH];
  logic [NUM_CH-1:0] r_mute;

  logic [ACC_W-1:0]  r_acc;
  logic [IDX_W-1:0]  r_idx;
  logic [15:0]       r_mix;
  logic [DCA_W-1:0]  r_dc_acc;
  logic [15:0]       r_audio_out;
  logic              r_audio_valid;

  logic              w_capture;
  logic              w_accum_en;
  logic              w_sat_en;
  logic              w_dc_en;
  logic              w_last_ch;
  logic [PROD_W-1:0] w_prod;
  logic [SHR_W-1:0]  w_acc_shr;
  logic [15:0]       w_mix_sat;
  logic [15:0]       w_dc;
  logic signed [16:0] w_diff;
  logic [DCA_W-1:0]  w_dc_acc_next;
  logic [15:0]       w_out_next;

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  assign w_last_ch = (r_idx == IDX_W'(NUM_CH - 1));

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (clk_48KHz_en) w_state_next = S_ACCUM;
      S_ACCUM: if (w_last_ch)    w_state_next = S_SAT;
      S_SAT:                     w_state_next = S_DCBLK;
      S_DCBLK:                   w_state_next = S_OUT;
      S_OUT:                     w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture  = (r_state == S_IDLE) && clk_48KHz_en;
    w_accum_en = (r_state == S_ACCUM);
    w_sat_en   = (r_state == S_SAT);
    w_dc_en    = (r_state == S_DCBLK);
    overrun    = reset_n && clk_48KHz_en && (r_state != S_IDLE);
  end

  // NOTE: the snapshot is not reset; it is always written at capture before ACCUM reads it.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_in[k]   <= ch_in[16*k +: 16];
        r_gain[k] <= ch_gain[GAIN_W*k +: GAIN_W];
      end
      r_mute <= ch_mute;
    end
  end

  assign w_prod = r_mute[r_idx] ? '0 : PROD_W'(r_in[r_idx]) * PROD_W'(r_gain[r_idx]);

  // Q1.7 gain: drop the 7 fractional bits, then saturate to the unsigned 16-bit range.
  assign w_acc_shr = r_acc[ACC_W-1:7];
  assign w_mix_sat = (w_acc_shr > SHR_W'(16'hFFFF)) ? 16'hFFFF : w_acc_shr[15:0];

  assign w_dc          = 16'(r_dc_acc >> DC_SHIFT);
  assign w_diff        = $signed({1'b0, r_mix}) - $signed({1'b0, w_dc});
  assign w_dc_acc_next = r_dc_acc + DCA_W'(r_mix) - DCA_W'(w_dc);

  always_comb begin
    if (w_diff > 17'sd32767)       w_out_next = 16'h7FFF;
    else if (w_diff < -17'sd32768) w_out_next = 16'h8000;
    else                           w_out_next = w_diff[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc         <= '0;
      r_idx         <= '0;
      r_mix         <= '0;
      r_dc_acc      <= '0;
      r_audio_out   <= '0;
      r_audio_valid <= 1'b0;
    end else begin
      r_audio_valid <= w_dc_en;
      if (w_capture) begin
        r_acc <= '0;
        r_idx <= '0;
      end
      if (w_accum_en) begin
        r_acc <= r_acc + ACC_W'(w_prod);
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_sat_en) r_mix <= w_mix_sat;
      if (w_dc_en) begin
        r_dc_acc    <= w_dc_acc_next;
        r_audio_out <= w_out_next;
      end
    end
  end

  assign audio_out   = r_audio_out;
  assign audio_valid = r_audio_valid;

endmodule

// File: tb/tb_discrete_audio_mixer.sv
// Randomized and directed checks of discrete_audio_mixer against a per-sample arithmetic model
// that tracks acceptance windows, output timing and the DC tracker.
module tb_discrete_audio_mixer;

  localparam int NUM_CH   = 4;
  localparam int GAIN_W   = 8;
  localparam int DC_SHIFT = 10;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     clk_48KHz_en;
  logic [NUM_CH*16-1:0]     ch_in;
  logic [NUM_CH*GAIN_W-1:0] ch_gain;
  logic [NUM_CH-1:0]        ch_mute;
  logic [15:0]              audio_out;
  logic                     audio_valid;
  logic                     overrun;

  discrete_audio_mixer #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .DC_SHIFT(DC_SHIFT)) dut (
    .clk(clk), .reset_n(reset_n), .clk_48KHz_en(clk_48KHz_en),
    .ch_in(ch_in), .ch_gain(ch_gain), .ch_mute(ch_mute),
    .audio_out(audio_out), .audio_valid(audio_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stimulus values
  int v_in [NUM_CH];
  int v_gain [NUM_CH];
  bit v_mute [NUM_CH];

  // reference model
  bit    m_active = 0;
  int    m_accept = 0;
  int    m_cyc = 0;
  int    m_in [NUM_CH];
  int    m_gain [NUM_CH];
  bit    m_mute [NUM_CH];
  longint m_dc_acc = 0;
  int    m_out = 0;
  int    m_valid = 0;

  int vcnt, ocnt;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic void model_sample();
    longint sum = 0;
    longint mix, dc, diff;
    for (int k = 0; k < NUM_CH; k++)
      if (!m_mute[k]) sum += longint'(m_in[k]) * longint'(m_gain[k]);
    mix = sum / 128;
    if (mix > 65535) mix = 65535;
    dc   = m_dc_acc / (longint'(1) << DC_SHIFT);
    diff = mix - dc;
    m_dc_acc = m_dc_acc + diff;
    if (diff > 32767) diff = 32767;
    if (diff < -32768) diff = -32768;
    m_out = int'(diff);
  endfunction

  task automatic cyc(input bit s, input bit r);
    bit busy, accept;
    @(negedge clk);
    reset_n      = r;
    clk_48KHz_en = s;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_in[16*k +: 16]         = 16'(v_in[k]);
      ch_gain[GAIN_W*k +: GAIN_W] = GAIN_W'(v_gain[k]);
      ch_mute[k]                = v_mute[k];
    end
    busy   = m_active && (m_cyc <= m_accept + NUM_CH + 3);
    accept = r && s && !busy;
    #1;
    check("overrun", int'(overrun), int'(r && s && busy));
    if (overrun) ocnt++;
    @(posedge clk);
    if (!r) begin
      m_active = 0; m_dc_acc = 0; m_out = 0; m_valid = 0;
    end else begin
      m_valid = (m_active && m_cyc == m_accept + NUM_CH + 2) ? 1 : 0;
      if (m_valid != 0) model_sample();
      if (accept) begin
        m_active = 1;
        m_accept = m_cyc;
        for (int k = 0; k < NUM_CH; k++) begin
          m_in[k] = v_in[k]; m_gain[k] = v_gain[k]; m_mute[k] = v_mute[k];
        end
      end
    end
    m_cyc++;
    #1;
    check("valid", int'(audio_valid), m_valid);
    check("audio_out", int'($signed(audio_out)), m_out);
    if (audio_valid) vcnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
  endtask

  task automatic sample();
    cyc(1'b1, 1'b1);
    idle(NUM_CH + 3);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
  endtask

  task automatic set_ch(input int k, input int val, input int g, input bit mu);
    v_in[k] = val; v_gain[k] = g; v_mute[k] = mu;
  endtask

  task automatic solo_ch0(input int val, input int g);
    set_ch(0, val, g, 1'b0);
    for (int k = 1; k < NUM_CH; k++) set_ch(k, $urandom_range(0, 65535), $urandom_range(0, 255), 1'b1);
  endtask

  int prev;

  initial begin
    for (int k = 0; k < NUM_CH; k++) set_ch(k, 0, 0, 1'b1);
    reset_n = 1'b0; clk_48KHz_en = 1'b0; ch_in = '0; ch_gain = '0; ch_mute = '1;

    // reset state, including a strobe held during reset
    do_reset();
    check("rst_out", int'(audio_out), 0);
    check("rst_valid", int'(audio_valid), 0);
    idle(2);

    // single unity channel, then slow DC tracking
    solo_ch0(1000, 128);
    sample();
    check("t1_first", int'($signed(audio_out)), 1000);
    sample();
    check("t1_second", int'($signed(audio_out)), 1000);
    prev = 1000;
    for (int i = 0; i < 20; i++) begin
      sample();
      check("t1_mono", int'(int'($signed(audio_out)) <= prev), 1);
      prev = int'($signed(audio_out));
    end

    // two-channel mix, then mute one channel
    do_reset();
    set_ch(0, 2000, 64, 1'b0);
    set_ch(1, 500, 255, 1'b0);
    for (int k = 2; k < NUM_CH; k++) set_ch(k, 12345, 200, 1'b1);
    sample();
    check("t2_first", int'($signed(audio_out)), 1996);
    v_mute[1] = 1'b1;
    sample();
    check("t2_muted", int'($signed(audio_out)), 999);

    // positive saturation
    do_reset();
    for (int k = 0; k < NUM_CH; k++) set_ch(k, 65535, 255, 1'b0);
    sample();
    check("t3_clamp", int'($signed(audio_out)), 32767);

    // settle DC, then mute for the negative path
    do_reset();
    solo_ch0(1000, 128);
    for (int i = 0; i < 3000; i++) sample();
    v_mute[0] = 1'b1;
    sample();
    check("t4_negative", int'(int'($signed(audio_out)) < -500), 1);
    prev = int'($signed(audio_out));
    for (int i = 0; i < 10; i++) sample();
    check("t4_decay", int'(int'($signed(audio_out)) > prev), 1);

    // overrun: second strobe 3 clocks after the first
    do_reset();
    idle(1);
    solo_ch0(3000, 128);
    vcnt = 0; ocnt = 0;
    cyc(1'b1, 1'b1);
    v_in[0] = 7777;
    idle(2);
    cyc(1'b1, 1'b1);
    idle(NUM_CH + 8);
    check("t5_valid_cnt", vcnt, 1);
    check("t5_ovr_cnt", ocnt, 1);
    check("t5_out", int'($signed(audio_out)), 3000);

    // strobe exactly on the OUT cycle is an overrun
    vcnt = 0; ocnt = 0;
    cyc(1'b1, 1'b1);
    idle(NUM_CH + 2);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    idle(NUM_CH + 6);
    check("t5b_ovr_cnt", ocnt, 1);
    check("t5b_valid_cnt", vcnt, 2);

    // reset during ACCUM discards the mix
    solo_ch0(4000, 128);
    vcnt = 0; ocnt = 0;
    cyc(1'b1, 1'b1);
    idle(1);
    cyc(1'b0, 1'b0);
    idle(NUM_CH + 6);
    check("t6_valid_cnt", vcnt, 0);
    check("t6_out", int'(audio_out), 0);
    check("t6_ovr_cnt", ocnt, 0);
    sample();
    check("t6_recover", int'($signed(audio_out)), 4000);

    // randomized stream with irregular spacing and occasional reset
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NUM_CH; k++)
        set_ch(k, $urandom_range(0, 65535), $urandom_range(0, 255), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) cyc($urandom_range(0, 1) == 1, 1'b0);
      else cyc($urandom_range(0, 3) != 0, 1'b1);
      idle($urandom_range(0, NUM_CH + 6));
    end
    idle(NUM_CH + 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
